// File: rtl/float_pkg.sv
// Shared float word layout, classification enum and NaN helper for the float FIFO slice.
package float_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic [2:0] {
        FLT_ZERO      = 3'd0,
        FLT_SUBNORMAL = 3'd1,
        FLT_NORMAL    = 3'd2,
        FLT_INF       = 3'd3,
        FLT_QNAN      = 3'd4,
        FLT_SNAN      = 3'd5
    } float_class_e;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    function automatic logic is_nan(input float_t f);
        return (f.exponent == EXP_MAX) && (f.mantissa != 23'd0);
    endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational decode of a float_t into its float_class_e category.
module float_classify
    import float_pkg::*;
(
    input  float_t       f_i,
    output float_class_e class_o
);

    always_comb begin
        class_o = FLT_NORMAL;
        if (f_i.exponent == 8'h00) begin
            if (f_i.mantissa == 23'd0) class_o = FLT_ZERO;
            else                       class_o = FLT_SUBNORMAL;
        end else if (f_i.exponent == EXP_MAX) begin
            if (!is_nan(f_i))          class_o = FLT_INF;
            else if (f_i.mantissa[22]) class_o = FLT_QNAN;
            else                       class_o = FLT_SNAN;
        end
    end

endmodule

// File: rtl/float_fifo.sv
// Valid/ready FIFO of float_t words with optional subnormal flush, head classification
// and a saturating count of accepted NaN pushes.
module float_fifo
    import float_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter bit FLUSH_DENORM = 1'b0,
    parameter int CNT_W        = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  float_t                     in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output float_t                     out_data_o,
    output float_class_e               out_class_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [CNT_W-1:0]           nan_count_o,
    input  logic                       stat_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    float_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] nan_q, nan_d;

    float_class_e in_class;
    float_t       wr_data;
    logic         push, pop, nan_push;

    float_classify u_in_class (.f_i(in_data_i), .class_o(in_class));
    float_classify u_head_class (.f_i(mem_q[rd_ptr_q]), .class_o(out_class_o));

    // Handshake: a word moves on a side only in a cycle where both valid and ready are high.
    // in_ready_o ignores out_ready_i, so a full FIFO never accepts even during a pop.
    assign in_ready_o  = rst_ni && (count_q != CW'(DEPTH));
    assign out_valid_o = rst_ni && (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign nan_count_o = nan_q;

    assign push     = in_valid_i && in_ready_o;
    assign pop      = out_valid_o && out_ready_i;
    assign nan_push = push && ((in_class == FLT_QNAN) || (in_class == FLT_SNAN));

    always_comb begin
        wr_data = in_data_i;
        if (FLUSH_DENORM && (in_class == FLT_SUBNORMAL)) begin
            wr_data = '{sign: in_data_i.sign, exponent: 8'h00, mantissa: 23'd0};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Clear wins over increment, but a NaN accepted in the clearing cycle still counts.
    always_comb begin
        nan_d = nan_q;
        if (stat_clr_i)                           nan_d = nan_push ? CNT_W'(1) : '0;
        else if (nan_push && (nan_q != '1))       nan_d = nan_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            nan_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            nan_q    <= nan_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
